// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the keypad scanner:
//   state_t      - key-event FSM states (IDLE, PRESSED, MULTI)
//   key_count_t  - classification of a debounced frame (no / one / many keys)
//   MAX_KEYS     - widest matrix the classifier accepts (ROWS*COLS <= MAX_KEYS)
//   code_width() - width of the key code for a ROWS x COLS matrix
//   key_count()  - zero / one / many classifier for a key frame
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KEYS_NONE = 2'd0,
        KEYS_ONE  = 2'd1,
        KEYS_MANY = 2'd2
    } key_count_t;

    localparam int MAX_KEYS = 64;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    // x & (x-1) clears the lowest set bit, so it is zero iff at most one bit is set.
    function automatic key_count_t key_count(input logic [MAX_KEYS-1:0] keys);
        if (keys == '0)
            return KEYS_NONE;
        else if ((keys & (keys - MAX_KEYS'(1))) == '0)
            return KEYS_ONE;
        else
            return KEYS_MANY;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Key-event channel from the scanner to the user-selection logic.
//   key_code  - code of the pressed key (row*COLS+col), stable while key_valid
//   key_valid - key_code holds an unconsumed event
//   key_ready - consumer accepts key_code when high together with key_valid
//   key_held  - exactly one key is held in the debounced state
//   overrun   - one-cycle pulse, an event was dropped while one was pending
// master = scanner side, slave = consumer side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic              key_held;
    logic              overrun;

    modport master (
        output key_code, key_valid, key_held, overrun,
        input  key_ready
    );

    modport slave (
        input  key_code, key_valid, key_held, overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_scanner_frame_debounce.sv
// -----------------------------------------------------------------------------
// frame_debounce
// Whole-frame debouncer. A new frame is accepted once DEBOUNCE consecutive
// identical frames follow a change; accept pulses for one cycle with the
// accepted frame already on deb_frame.
//   clk, rst    - clock, synchronous active-high reset
//   frame_done  - a complete scan frame is on new_frame this cycle
//   new_frame   - pressed-key bitmap, bit index = row*COLS+col
//   accept      - one-cycle strobe, deb_frame was just loaded
//   deb_frame   - last accepted frame
// -----------------------------------------------------------------------------
module frame_debounce #(
    parameter int KEYS     = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_done,
    input  logic [KEYS-1:0] new_frame,
    output logic            accept,
    output logic [KEYS-1:0] deb_frame
);

    localparam int               CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [KEYS-1:0]  prev_frame;
    logic [CNT_W-1:0] stable_cnt;
    logic             same;

    assign same = (new_frame == prev_frame);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_frame <= '0;
            stable_cnt <= '0;
            deb_frame  <= '0;
            accept     <= 1'b0;
        end else begin
            accept <= 1'b0;
            if (frame_done) begin
                prev_frame <= new_frame;
                if (!same) begin
                    stable_cnt <= '0;
                end else if (stable_cnt != CNT_MAX) begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                    // Accept only on the step into saturation, not while parked there.
                    if (stable_cnt == CNT_MAX - CNT_W'(1)) begin
                        accept    <= 1'b1;
                        deb_frame <= new_frame;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a ROWS x COLS push-button matrix one row at a time, debounces whole
// frames and emits one key code per clean single-key press.
//   clk, rst - clock, synchronous active-high reset
//   row_o    - row strobes, active-low, exactly one low
//   col_i    - column sense lines, active-low, asynchronous
//   key_bus  - key-event channel (code/valid/ready, held, overrun)
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROWS-1:0]  row_o,
    input  logic [COLS-1:0]  col_i,
    keypad_scanner_if.master key_bus
);

    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    // ---------------- column synchronizer ----------------
    logic [COLS-1:0] col_meta, col_sync, cols_pressed;

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <=, so both flops sample the old values and form a real 2-stage chain.
        if (rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
        end
    end

    assign cols_pressed = ~col_sync;

    // ---------------- prescaler, row strobe, frame buffer ----------------
    logic [PRE_W-1:0] presc;
    logic [ROW_W-1:0] row_idx;
    logic [KEYS-1:0]  frame_buf;
    logic [KEYS-1:0]  new_frame;
    logic             tick, frame_done;

    assign tick       = (presc == PRE_W'(SCAN_DIV - 1));
    assign frame_done = tick && (row_idx == ROW_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            row_idx   <= '0;
            row_o     <= ~ROWS'(1);
            // NOTE: the frame buffer is reset on purpose; a stale frame would be debounced as a real press after reset.
            frame_buf <= '0;
        end else if (tick) begin
            presc                           <= '0;
            frame_buf[row_idx*COLS +: COLS] <= cols_pressed;
            row_idx <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
            row_o   <= {row_o[ROWS-2:0], row_o[ROWS-1]};
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    // The last row is still in flight on the frame-complete edge; splice it in.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        new_frame = frame_buf;
        new_frame[(ROWS-1)*COLS +: COLS] = cols_pressed;
    end

    // ---------------- frame debouncer ----------------
    logic            accept;
    logic [KEYS-1:0] deb_frame;

    frame_debounce #(
        .KEYS     (KEYS),
        .DEBOUNCE (DEBOUNCE)
    ) u_frame_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done),
        .new_frame  (new_frame),
        .accept     (accept),
        .deb_frame  (deb_frame)
    );

    // ---------------- encoder ----------------
    // Frame bit index equals row*COLS+col, so the key code is the set-bit index.
    logic [CODE_W-1:0] deb_code;
    key_count_t        deb_count;

    always_comb begin
        deb_code = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (deb_frame[i]) deb_code = CODE_W'(i);
        end
    end

    assign deb_count = key_count(MAX_KEYS'(deb_frame));

    // ---------------- key-event FSM ----------------
    state_t            state, next_state;
    logic              emit, load_held;
    logic [CODE_W-1:0] held_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            held_code <= '0;
        end else begin
            state <= next_state;
            if (load_held) held_code <= deb_code;
        end
    end

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        load_held  = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    case (deb_count)
                        KEYS_ONE: begin
                            next_state = PRESSED;
                            emit       = 1'b1;
                            load_held  = 1'b1;
                        end
                        KEYS_MANY: next_state = MULTI;
                        default:   next_state = IDLE;
                    endcase
                end
                PRESSED: begin
                    case (deb_count)
                        KEYS_NONE: next_state = IDLE;
                        KEYS_MANY: next_state = MULTI;
                        // Direct swap to another single key is not trusted as a press.
                        default:   if (deb_code != held_code) next_state = IDLE;
                    endcase
                end
                MULTI: begin
                    case (deb_count)
                        KEYS_NONE: next_state = IDLE;
                        // Leftover key after a rollover: hold it but emit no code.
                        KEYS_ONE: begin
                            next_state = PRESSED;
                            load_held  = 1'b1;
                        end
                        default: next_state = MULTI;
                    endcase
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // ---------------- handshake ----------------
    logic [CODE_W-1:0] key_code;
    logic              key_valid, overrun, xfer;

    assign xfer = key_valid && key_bus.key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (emit) begin
                if (!key_valid || xfer) begin
                    key_code  <= deb_code;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                key_valid <= 1'b0;
            end
        end
    end

    assign key_bus.key_code  = key_code;
    assign key_bus.key_valid = key_valid;
    assign key_bus.overrun   = overrun;
    assign key_bus.key_held  = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2).
// A behavioural key matrix pulls a column low while its key is pressed and
// its row strobe is low. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int CODE_W   = code_width(ROWS, COLS);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ROWS-1:0]  row_o;
    logic [COLS-1:0]  col_i;
    logic [ROWS*COLS-1:0] keys = '0;

    int compared   = 0;
    int mismatched = 0;
    int xfer_cnt   = 0;
    int ovr_cnt    = 0;
    logic [CODE_W-1:0] last_code = '0;

    keypad_scanner_if #(.CODE_W(CODE_W)) key_bus ();

    keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_o   (row_o),
        .col_i   (col_i),
        .key_bus (key_bus)
    );

    always #5 clk = ~clk;

    // Key matrix model.
    always_comb begin
        col_i = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_o[r] && keys[r*COLS+c]) col_i[c] = 1'b0;
    end

    // Transfer and overrun monitor (pre-edge values).
    always @(posedge clk) begin
        if (key_bus.key_valid && key_bus.key_ready) begin
            xfer_cnt++;
            last_code = key_bus.key_code;
        end
        if (key_bus.overrun) ovr_cnt++;
    end

    // Global watchdog.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // which: 0 key_valid high, 1 key_held high, 2 key_held low
    task automatic wait_for(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = key_bus.key_valid;
                1:       ok = key_bus.key_held;
                2:       ok = !key_bus.key_held;
                default: ok = 1'b0;
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_bus.key_ready = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        compared++; if (row_o !== 4'b1110) begin mismatched++; $display("FAIL reset_row: got %b, expected 1110", row_o); end
        compared++; if (key_bus.key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b, expected 0", key_bus.key_valid); end
        compared++; if (key_bus.key_code !== 4'd0) begin mismatched++; $display("FAIL reset_code: got %0d, expected 0", key_bus.key_code); end
        compared++; if (key_bus.key_held !== 1'b0) begin mismatched++; $display("FAIL reset_held: got %b, expected 0", key_bus.key_held); end
        compared++; if (key_bus.overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b, expected 0", key_bus.overrun); end
        rst = 1'b0;
    endtask

    // Must be entered on the negedge where rst was released.
    task automatic test_idle_scan();
        int row_bad = 0;
        logic [ROWS-1:0] exp_row, bad_row, bad_exp;
        bit valid_seen = 1'b0;
        bad_row = '0;
        bad_exp = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((k / SCAN_DIV) % ROWS));
            if (row_o !== exp_row) begin
                if (row_bad == 0) begin bad_row = row_o; bad_exp = exp_row; end
                row_bad++;
            end
            if (key_bus.key_valid) valid_seen = 1'b1;
        end
        compared++; if (row_bad != 0) begin mismatched++; $display("FAIL idle_row_sequence: got %b, expected %b (%0d bad cycles)", bad_row, bad_exp, row_bad); end
        compared++; if (valid_seen) begin mismatched++; $display("FAIL idle_no_valid: got key_valid 1, expected 0"); end
    endtask

    task automatic test_single_key();
        bit ok;
        int base = xfer_cnt;
        key_bus.key_ready = 1'b1;
        keys[9] = 1'b1;
        wait_for(0, 300, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL single_valid_timeout: got no key_valid, expected a pulse"); end
        compared++; if (key_bus.key_code !== 4'd9) begin mismatched++; $display("FAIL single_code: got %0d, expected 9", key_bus.key_code); end
        compared++; if (key_bus.key_held !== 1'b1) begin mismatched++; $display("FAIL single_held_rise: got %b, expected 1", key_bus.key_held); end
        repeat (60) @(negedge clk);
        compared++; if (xfer_cnt - base != 1) begin mismatched++; $display("FAIL single_one_event: got %0d events, expected 1", xfer_cnt - base); end
        compared++; if (key_bus.key_held !== 1'b1) begin mismatched++; $display("FAIL single_held_kept: got %b, expected 1", key_bus.key_held); end
        keys[9] = 1'b0;
        repeat (20) @(negedge clk);
        compared++; if (key_bus.key_held !== 1'b1) begin mismatched++; $display("FAIL single_held_early_drop: got %b, expected 1", key_bus.key_held); end
        wait_for(2, 200, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL single_release_timeout: got key_held 1, expected 0"); end
        compared++; if (last_code !== 4'd9 || xfer_cnt - base != 1) begin mismatched++; $display("FAIL single_transfer: got code %0d / %0d events, expected 9 / 1", last_code, xfer_cnt - base); end
    endtask

    task automatic test_bounce();
        bit ok;
        int base, obase;
        repeat (40) @(negedge clk);
        base  = xfer_cnt;
        obase = ovr_cnt;
        keys[6] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            repeat (3) @(negedge clk);
            keys[6] = ~keys[6];
        end
        keys[6] = 1'b1;
        wait_for(1, 300, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL bounce_held_timeout: got key_held 0, expected 1"); end
        repeat (100) @(negedge clk);
        compared++; if (xfer_cnt - base != 1) begin mismatched++; $display("FAIL bounce_one_event: got %0d events, expected 1", xfer_cnt - base); end
        compared++; if (last_code !== 4'd6) begin mismatched++; $display("FAIL bounce_code: got %0d, expected 6", last_code); end
        compared++; if (ovr_cnt != obase) begin mismatched++; $display("FAIL bounce_overrun: got %0d pulses, expected 0", ovr_cnt - obase); end
        keys = '0;
        wait_for(2, 300, ok);
    endtask

    task automatic test_multi();
        bit ok;
        int base = xfer_cnt;
        keys[0] = 1'b1;
        keys[5] = 1'b1;
        repeat (120) @(negedge clk);
        compared++; if (xfer_cnt != base) begin mismatched++; $display("FAIL multi_no_event: got %0d events, expected 0", xfer_cnt - base); end
        compared++; if (key_bus.key_held !== 1'b0) begin mismatched++; $display("FAIL multi_held: got %b, expected 0", key_bus.key_held); end
        keys[5] = 1'b0;
        wait_for(1, 300, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL multi_single_held_timeout: got key_held 0, expected 1"); end
        compared++; if (xfer_cnt != base || key_bus.key_valid !== 1'b0) begin mismatched++; $display("FAIL multi_rollover_event: got %0d events / valid %b, expected 0 / 0", xfer_cnt - base, key_bus.key_valid); end
        keys = '0;
        wait_for(2, 300, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL multi_release_timeout: got key_held 1, expected 0"); end
        keys[3] = 1'b1;
        wait_for(0, 300, ok);
        compared++; if (!ok || key_bus.key_code !== 4'd3) begin mismatched++; $display("FAIL multi_next_code: got %0d (valid seen %b), expected 3", key_bus.key_code, ok); end
        keys = '0;
        wait_for(2, 300, ok);
    endtask

    task automatic test_overrun();
        bit ok;
        int base, obase;
        key_bus.key_ready = 1'b0;
        repeat (20) @(negedge clk);
        base  = xfer_cnt;
        obase = ovr_cnt;
        keys[4] = 1'b1;
        wait_for(0, 300, ok);
        compared++; if (!ok || key_bus.key_code !== 4'd4) begin mismatched++; $display("FAIL ovr_first_code: got %0d (valid seen %b), expected 4", key_bus.key_code, ok); end
        keys = '0;
        wait_for(2, 300, ok);
        keys[7] = 1'b1;
        wait_for(1, 300, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL ovr_second_held_timeout: got key_held 0, expected 1"); end
        repeat (5) @(negedge clk);
        compared++; if (ovr_cnt - obase != 1) begin mismatched++; $display("FAIL ovr_pulse_count: got %0d, expected 1", ovr_cnt - obase); end
        compared++; if (key_bus.key_code !== 4'd4 || key_bus.key_valid !== 1'b1) begin mismatched++; $display("FAIL ovr_code_kept: got %0d valid %b, expected 4 valid 1", key_bus.key_code, key_bus.key_valid); end
        key_bus.key_ready = 1'b1;
        @(negedge clk);
        compared++; if (key_bus.key_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_valid_drop: got %b, expected 0", key_bus.key_valid); end
        compared++; if (xfer_cnt - base != 1 || last_code !== 4'd4) begin mismatched++; $display("FAIL ovr_transfer: got %0d events code %0d, expected 1 code 4", xfer_cnt - base, last_code); end
        keys = '0;
        wait_for(2, 300, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        key_bus.key_ready = 1'b0;
        keys[2] = 1'b1;
        wait_for(0, 300, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL rstmid_valid_timeout: got no key_valid, expected 1"); end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (key_bus.key_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %b, expected 0", key_bus.key_valid); end
        compared++; if (key_bus.key_code !== 4'd0) begin mismatched++; $display("FAIL rstmid_code: got %0d, expected 0", key_bus.key_code); end
        compared++; if (key_bus.key_held !== 1'b0) begin mismatched++; $display("FAIL rstmid_held: got %b, expected 0", key_bus.key_held); end
        compared++; if (row_o !== 4'b1110) begin mismatched++; $display("FAIL rstmid_row: got %b, expected 1110", row_o); end
        compared++; if (key_bus.overrun !== 1'b0) begin mismatched++; $display("FAIL rstmid_overrun: got %b, expected 0", key_bus.overrun); end
        keys = '0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        key_bus.key_ready = 1'b0;
        test_reset();
        test_idle_scan();
        test_single_key();
        test_bounce();
        test_multi();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
